// File: rtl/mem_responder.sv
// Wait-state memory responder for the MAR/MDR datapath: single-word read/write with a one-cycle MFC pulse.
// Optional feature macro MEM_RANGE_CHECK_EN: accesses at addresses >= DEPTH raise err and are suppressed.
//
// state | meaning
// IDLE  | waiting for a read/write strobe
// BUSY  | counting wait states; the access happens on the edge where the counter is zero
// DONE  | MFC high for this cycle, then back to IDLE
module mem_responder #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 512,
  parameter int ADDR_W      = 9,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       address,
  input  logic [DATA_W-1:0] MDRout,
  output logic [DATA_W-1:0] Mdatain,
  output logic              MFC,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                op_wr_q, op_wr_d;
  logic                oor_q, oor_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                mfc_q, mfc_d;
  logic                err_q, err_d;
  logic                mem_we;
  logic                oor_now;
  logic [DATA_W-1:0]   mem_q [DEPTH];

`ifdef MEM_RANGE_CHECK_EN
  assign oor_now = (address >= 32'(DEPTH));
`else
  // Upper address bits are deliberately ignored; the index wraps.
  logic unused_addr_hi;
  assign unused_addr_hi = ^address[31:ADDR_W];
  assign oor_now        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_wr_d = op_wr_q;
    oor_d   = oor_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mfc_d   = 1'b0;
    err_d   = 1'b0;
    mem_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (read || write) begin
          idx_d   = address[ADDR_W-1:0];
          wdata_d = MDRout;
          op_wr_d = write & ~read;   // simultaneous strobes resolve to a read
          oor_d   = oor_now;
          cnt_d   = 4'(WAIT_STATES);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          mfc_d   = 1'b1;
          err_d   = oor_q;
          state_d = DONE;
          if (op_wr_q) begin
            mem_we = ~oor_q;
          end else begin
            rdata_d = oor_q ? '0 : mem_q[idx_q];
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      op_wr_q <= 1'b0;
      oor_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      mfc_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      oor_q   <= oor_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      mfc_q   <= mfc_d;
      err_q   <= err_d;
    end
  end

  // Array contents survive clr; mem_we can only be high in BUSY, so an aborted write never lands.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign Mdatain = rdata_q;
  assign MFC     = mfc_q;
  assign busy    = (state_q != IDLE);
  assign err     = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed scenarios plus randomized traffic against a word-array reference model.
// Honours MEM_RANGE_CHECK_EN when computing expectations.
module tb_mem_responder;
  localparam int DW    = 32;
  localparam int DEPTH = 512;
  localparam int AW    = 9;
  localparam int WS    = 2;

  logic clk = 1'b0;
  logic clr;
  logic read, write, MFC, busy, err;
  logic [31:0] address, MDRout, Mdatain;
  logic read0, write0, MFC0, busy0, err0;
  logic [31:0] address0, MDRout0, Mdatain0;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_mem [DEPTH];
  bit          model_vld [DEPTH];
  logic [31:0] model_md;
  bit          model_md_known;

  always #5 clk = ~clk;

  mem_responder #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .WAIT_STATES(WS)) dut (
    .clk(clk), .clr(clr), .read(read), .write(write), .address(address), .MDRout(MDRout),
    .Mdatain(Mdatain), .MFC(MFC), .busy(busy), .err(err));

  mem_responder #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .WAIT_STATES(0)) dut0 (
    .clk(clk), .clr(clr), .read(read0), .write(write0), .address(address0), .MDRout(MDRout0),
    .Mdatain(Mdatain0), .MFC(MFC0), .busy(busy0), .err(err0));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete transaction on dut, checked against the model; noise toggles strobes while busy.
  task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input bit noise);
    int          lat;
    bit          seen;
    bit          oor;
    int          idx;
    logic [31:0] exp_md;
    bit          exp_known;
    oor = 1'b0;
`ifdef MEM_RANGE_CHECK_EN
    oor = (addr >= 32'(DEPTH));
`endif
    idx = int'(addr % 32'(DEPTH));
    if (rd) begin
      if (oor) begin
        exp_md    = 32'd0;
        exp_known = 1'b1;
      end else begin
        exp_md    = model_mem[idx];
        exp_known = model_vld[idx];
      end
    end else begin
      exp_md    = model_md;
      exp_known = model_md_known;
    end

    @(negedge clk);
    read = rd; write = wr; address = addr; MDRout = data;
    @(posedge clk); #1;
    check("busy_after_accept", 32'(busy), 32'd1);
    read = 1'b0; write = 1'b0;
    lat = 0; seen = 1'b0;
    while (!seen && lat < 40) begin
      if (noise) begin
        read = 1'($urandom_range(0, 1)); write = 1'($urandom_range(0, 1));
        address = $urandom; MDRout = $urandom;
      end
      @(posedge clk); #1;
      lat++;
      if (MFC) seen = 1'b1;
    end
    check("mfc_latency", 32'(lat), 32'(WS + 1));
    check("err_with_mfc", 32'(err), 32'(oor));
    if (exp_known) check("mdatain", Mdatain, exp_md);
    if (noise) begin
      read = 1'($urandom_range(0, 1)); write = 1'($urandom_range(0, 1));
      address = $urandom; MDRout = $urandom;
    end
    @(posedge clk); #1;
    check("mfc_one_cycle", 32'(MFC), 32'd0);
    check("busy_back_idle", 32'(busy), 32'd0);
    read = 1'b0; write = 1'b0;

    if (rd) begin
      model_md       = exp_md;
      model_md_known = exp_known;
    end else if (wr && !oor) begin
      model_mem[idx] = data;
      model_vld[idx] = 1'b1;
    end
  endtask

  initial begin
    logic [31:0] a;
    int          op;

    read = 0; write = 0; address = 0; MDRout = 0;
    read0 = 0; write0 = 0; address0 = 0; MDRout0 = 0;
    model_md = 32'd0; model_md_known = 1'b1;
    for (int i = 0; i < DEPTH; i++) model_vld[i] = 1'b0;

    clr = 1'b1;
    #1;
    check("rst_mdatain", Mdatain, 32'd0);
    check("rst_mfc", 32'(MFC), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    #20;
    @(negedge clk) clr = 1'b0;

    // write then read back
    access(1'b0, 1'b1, 32'd5, 32'hDEADBEEF, 1'b0);
    access(1'b1, 1'b0, 32'd5, 32'd0, 1'b0);
    check("read5_const", Mdatain, 32'hDEADBEEF);

    // simultaneous strobes act as a read
    access(1'b0, 1'b1, 32'd7, 32'h1234, 1'b0);
    access(1'b1, 1'b1, 32'd7, 32'hFFFF, 1'b0);
    check("rdwr_is_read", Mdatain, 32'h1234);
    access(1'b1, 1'b0, 32'd7, 32'd0, 1'b0);

    // address 600: wraps to 88, or flagged when range checking is built in
    access(1'b0, 1'b1, 32'd88, 32'hA5A5_0088, 1'b0);
    access(1'b0, 1'b1, 32'd600, 32'h0060_0600, 1'b0);
    access(1'b1, 1'b0, 32'd88, 32'd0, 1'b0);
    access(1'b1, 1'b0, 32'd600, 32'd0, 1'b0);

    // clr in the middle of a write aborts it
    access(1'b0, 1'b1, 32'd20, 32'h1111_1111, 1'b0);
    access(1'b1, 1'b0, 32'd20, 32'd0, 1'b0);
    @(negedge clk);
    write = 1'b1; address = 32'd20; MDRout = 32'h2222_2222;
    @(posedge clk); #1;
    write = 1'b0;
    @(posedge clk); #1;
    clr = 1'b1;
    #1;
    check("clr_mdatain", Mdatain, 32'd0);
    check("clr_mfc", 32'(MFC), 32'd0);
    check("clr_busy", 32'(busy), 32'd0);
    model_md = 32'd0; model_md_known = 1'b1;
    @(negedge clk) clr = 1'b0;
    repeat (4) @(posedge clk);
    access(1'b1, 1'b0, 32'd20, 32'd0, 1'b0);

    // zero wait states: held read strobe is accepted every third edge
    @(negedge clk);
    read0 = 1'b1; address0 = 32'd3;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #1;
      check("ws0_mfc", 32'(MFC0), 32'((k % 3) == 1));
      check("ws0_busy", 32'(busy0), 32'((k % 3) != 2));
    end
    read0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("ws0_idle", 32'(busy0), 32'd0);

    // randomized traffic with strobe noise while busy
    for (int n = 0; n < 40; n++) begin
      a = 32'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) a = a + 32'(512 * $urandom_range(1, 3));
      op = $urandom_range(0, 2);
      access(op != 1, op != 0, a, $urandom, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
